// File: rtl/vector_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// vector_sequencer_pkg
// Shared types and constants for the vector sequencer:
//   OP_W       - operand width of every stimulus/response nibble
//   state_e    - sequencer FSM states
//   vec_rec_t  - one table entry {a, b, c, exp}
//   misr_step  - one signature compaction step (only with VECTOR_SEQUENCER_MISR_EN)
// -----------------------------------------------------------------------------
package vector_sequencer_pkg;

  localparam int OP_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
    logic [OP_W-1:0] c;
    logic [OP_W-1:0] exp;
  } vec_rec_t;

`ifdef VECTOR_SEQUENCER_MISR_EN
  // x^16 + x^12 + x^5 + 1, feedback taps below the x^16 term.
  localparam logic [15:0] MISR_POLY = 16'h1021;

  // Shift left with feedback from bit 15, then fold the response into [3:0].
  function automatic logic [15:0] misr_step(input logic [15:0] sig,
                                            input logic [OP_W-1:0] din);
    logic [15:0] nxt;
    nxt = {sig[14:0], 1'b0} ^ (sig[15] ? MISR_POLY : 16'h0000);
    nxt[OP_W-1:0] = nxt[OP_W-1:0] ^ din;
    return nxt;
  endfunction
`endif

endpackage

// File: rtl/vector_sequencer_rom.sv
// -----------------------------------------------------------------------------
// vector_sequencer_rom
// Combinational vector table. Each record is {a, b, c, exp}, 4 bits each.
// Ports:
//   idx  in  [3:0]  table index
//   rec  out [15:0] packed vec_rec_t record; unused slots read as zero
// -----------------------------------------------------------------------------
module vector_sequencer_rom
  import vector_sequencer_pkg::*;
(
  input  logic [3:0]  idx,
  output logic [15:0] rec
);

  // NOTE: this table is pure decode logic, not storage, so it has no reset.
  always_comb begin
    case (idx)
      4'd0:    rec = 16'h0FA1;
      4'd1:    rec = 16'h8FA0;
      4'd2:    rec = 16'h98A0;
      4'd3:    rec = 16'h2BB0;
      4'd4:    rec = 16'hAFF0;
      4'd5:    rec = 16'h13F1;
      4'd6:    rec = 16'h9BF0;
      4'd7:    rec = 16'hD2A1;
      4'd8:    rec = 16'h6B11;
      4'd9:    rec = 16'h6C90;
      default: rec = 16'h0000;
    endcase
  end

endmodule

// File: rtl/vector_sequencer.sv
// -----------------------------------------------------------------------------
// vector_sequencer
// Applies NUM_VECTORS stored stimulus vectors to an external DUT, waits
// SETTLE_CYCLES clocks for each, compares the DUT response with the stored
// expected value and reports a pass/fail summary.
// Parameters:
//   NUM_VECTORS    vectors per run (1..16)
//   SETTLE_CYCLES  clocks between applying a vector and checking (1..15)
// Ports:
//   clk                   clock, rising edge
//   reset                 asynchronous, active-low reset
//   start                 begin a run (honoured in IDLE or DONE only)
//   a_out/b_out/c_out     registered stimulus to the DUT
//   y_in                  DUT response
//   busy                  run in progress
//   done, pass            run finished / finished without mismatches
//   err_count             saturating mismatch count
//   vec_idx               current vector index
//   first_fail            index of first mismatch, 4'hF if none
//   signature             16-bit MISR of responses (only with
//                         VECTOR_SEQUENCER_MISR_EN defined)
// -----------------------------------------------------------------------------
module vector_sequencer
  import vector_sequencer_pkg::*;
#(
  parameter int NUM_VECTORS   = 10,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [3:0]  a_out,
  output logic [3:0]  b_out,
  output logic [3:0]  c_out,
  input  logic [3:0]  y_in,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [3:0]  err_count,
  output logic [3:0]  vec_idx,
  output logic [3:0]  first_fail
`ifdef VECTOR_SEQUENCER_MISR_EN
  ,
  output logic [15:0] signature
`endif
);

  localparam logic [3:0] LAST_VEC    = 4'(NUM_VECTORS - 1);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] NO_FAIL     = 4'hF;
  localparam logic [3:0] ERR_MAX     = 4'hF;

  state_e     state_q, state_d;
  logic [3:0] settle_cnt_q, settle_cnt_d;
  logic [3:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [3:0] vec_idx_q, vec_idx_d;
  logic [3:0] err_q, err_d;
  logic [3:0] first_fail_q, first_fail_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic       mismatch;

  logic [15:0] rom_rec;
  vec_rec_t    rec;

  vector_sequencer_rom u_rom (
    .idx (vec_idx_q),
    .rec (rom_rec)
  );

  assign rec = vec_rec_t'(rom_rec);

  // The table entry is addressed by vec_idx_q, which is stable from APPLY
  // through CHECK, so the expected value matches the applied stimulus.
  assign mismatch = (y_in != rec.exp);

`ifdef VECTOR_SEQUENCER_MISR_EN
  logic [15:0] sig_q, sig_d;
`endif

  // NOTE: every signal written here gets its hold value first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    c_d          = c_q;
    vec_idx_d    = vec_idx_q;
    err_d        = err_q;
    first_fail_d = first_fail_q;
    done_d       = done_q;
    pass_d       = pass_q;
`ifdef VECTOR_SEQUENCER_MISR_EN
    sig_d        = sig_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d      = ST_APPLY;
          vec_idx_d    = 4'd0;
          err_d        = 4'd0;
          first_fail_d = 4'd0;
          done_d       = 1'b0;
          pass_d       = 1'b0;
`ifdef VECTOR_SEQUENCER_MISR_EN
          // Each run gets its own signature so repeated runs are comparable.
          sig_d        = 16'hFFFF;
`endif
        end
      end

      ST_APPLY: begin
        a_d          = rec.a;
        b_d          = rec.b;
        c_d          = rec.c;
        settle_cnt_d = 4'd0;
        state_d      = ST_SETTLE;
      end

      ST_SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          state_d = ST_CHECK;
        end else begin
          settle_cnt_d = settle_cnt_q + 4'd1;
        end
      end

      ST_CHECK: begin
`ifdef VECTOR_SEQUENCER_MISR_EN
        sig_d = misr_step(sig_q, y_in);
`endif
        if (mismatch) begin
          if (err_q != ERR_MAX) begin
            err_d = err_q + 4'd1;
          end
          // err_count never returns to zero within a run, so zero means
          // this is the first mismatch.
          if (err_q == 4'd0) begin
            first_fail_d = vec_idx_q;
          end
        end

        if (vec_idx_q == LAST_VEC) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          pass_d  = (err_q == 4'd0) && !mismatch;
          if ((err_q == 4'd0) && !mismatch) begin
            first_fail_d = NO_FAIL;
          end
        end else begin
          vec_idx_d = vec_idx_q + 4'd1;
          state_d   = ST_APPLY;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before this edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      settle_cnt_q <= 4'd0;
      a_q          <= 4'd0;
      b_q          <= 4'd0;
      c_q          <= 4'd0;
      vec_idx_q    <= 4'd0;
      err_q        <= 4'd0;
      first_fail_q <= NO_FAIL;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      c_q          <= c_d;
      vec_idx_q    <= vec_idx_d;
      err_q        <= err_d;
      first_fail_q <= first_fail_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
    end
  end

`ifdef VECTOR_SEQUENCER_MISR_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sig_q <= 16'hFFFF;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign signature = sig_q;
`endif

  assign a_out      = a_q;
  assign b_out      = b_q;
  assign c_out      = c_q;
  assign vec_idx    = vec_idx_q;
  assign err_count  = err_q;
  assign first_fail = first_fail_q;
  assign done       = done_q;
  assign pass       = pass_q;
  // Decoded straight from the state register, so it drops with reset.
  assign busy       = (state_q == ST_APPLY) || (state_q == ST_SETTLE) ||
                      (state_q == ST_CHECK);

endmodule

// File: tb/tb_vector_sequencer.sv
// -----------------------------------------------------------------------------
// tb_vector_sequencer
// Self-checking bench for vector_sequencer. A reference model built from the
// published vector table predicts error count, first failure, pass flag,
// run length and (with VECTOR_SEQUENCER_MISR_EN) the signature.
// -----------------------------------------------------------------------------
module tb_vector_sequencer;

  localparam int NV = 10;

  // Published table, entry k: (A,B,C) -> Y
  localparam int REF_A [NV] = '{0, 8, 9, 2, 10, 1, 9, 13, 6, 6};
  localparam int REF_B [NV] = '{15, 15, 8, 11, 15, 3, 11, 2, 11, 12};
  localparam int REF_C [NV] = '{10, 10, 10, 11, 15, 15, 15, 10, 1, 9};
  localparam int REF_Y [NV] = '{1, 0, 0, 0, 0, 1, 0, 1, 1, 0};

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       start16;
  logic [3:0] a_out, b_out, c_out, y_in;
  logic       busy, done, pass;
  logic [3:0] err_count, vec_idx, first_fail;
  logic [3:0] a16, b16, c16, y16;
  logic       busy16, done16, pass16;
  logic [3:0] err16, idx16, ff16;
`ifdef VECTOR_SEQUENCER_MISR_EN
  logic [15:0] signature, signature16;
`endif

  // Stimulus controls for the response path.
  logic [3:0] fault_mask [16];
  int         zero_vec;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vector_sequencer #(.NUM_VECTORS(10), .SETTLE_CYCLES(3)) dut (
    .clk(clk), .reset(reset), .start(start),
    .a_out(a_out), .b_out(b_out), .c_out(c_out), .y_in(y_in),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .vec_idx(vec_idx), .first_fail(first_fail)
`ifdef VECTOR_SEQUENCER_MISR_EN
    , .signature(signature)
`endif
  );

  vector_sequencer #(.NUM_VECTORS(16), .SETTLE_CYCLES(3)) dut16 (
    .clk(clk), .reset(reset), .start(start16),
    .a_out(a16), .b_out(b16), .c_out(c16), .y_in(y16),
    .busy(busy16), .done(done16), .pass(pass16), .err_count(err16),
    .vec_idx(idx16), .first_fail(ff16)
`ifdef VECTOR_SEQUENCER_MISR_EN
    , .signature(signature16)
`endif
  );

  // Golden DUT: answer whatever stimulus is presented using the table.
  function automatic logic [3:0] golden_y(input logic [3:0] a, input logic [3:0] b,
                                          input logic [3:0] c);
    logic [3:0] y;
    y = 4'd0;
    for (int k = 0; k < NV; k++) begin
      if (int'(a) == REF_A[k] && int'(b) == REF_B[k] && int'(c) == REF_C[k]) begin
        y = 4'(REF_Y[k]);
      end
    end
    return y;
  endfunction

  always_comb begin
    if (zero_vec == int'(vec_idx)) y_in = 4'd0;
    else                           y_in = golden_y(a_out, b_out, c_out) ^ fault_mask[vec_idx];
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

`ifdef VECTOR_SEQUENCER_MISR_EN
  function automatic logic [15:0] ref_misr(input logic [15:0] s, input logic [3:0] y);
    int v;
    v = (int'(s) * 2) % 65536;
    if (int'(s) >= 32768) v = v ^ 'h1021;
    v = v ^ int'(y);
    return 16'(v);
  endfunction
`endif

  // Predicted outcome of one 10-vector run with the current fault controls.
  task automatic model_run(output logic [3:0] e, output logic [3:0] ff,
                           output logic p, output logic [15:0] sig);
    int errs;
    logic [3:0] y;
    errs = 0;
    ff   = 4'hF;
    sig  = 16'hFFFF;
    for (int k = 0; k < NV; k++) begin
      if (zero_vec == k) y = 4'd0;
      else               y = 4'(REF_Y[k]) ^ fault_mask[k];
`ifdef VECTOR_SEQUENCER_MISR_EN
      sig = ref_misr(sig, y);
`endif
      if (int'(y) != REF_Y[k]) begin
        if (errs == 0) ff = 4'(k);
        errs++;
      end
    end
    e = (errs > 15) ? 4'hF : 4'(errs);
    p = (errs == 0);
  endtask

  // Pulse start for one cycle, check cleared counters, then count clocks
  // until done. Optional spurious starts while busy probe the ignore rule.
  task automatic run_dut(input bit spurious, output int n);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("clr_err",   16'(err_count),  16'd0);
    check("clr_ff",    16'(first_fail), 16'd0);
    check("clr_idx",   16'(vec_idx),    16'd0);
    check("clr_done",  16'(done),       16'd0);
    check("clr_pass",  16'(pass),       16'd0);
    check("clr_busy",  16'(busy),       16'd1);
    n = 0;
    while (!done && n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      start = spurious && (n == 7 || n == 23 || n == 40);
      if (spurious && (n == 8 || n == 24 || n == 41)) begin
        check("busy_idx",  16'(vec_idx), 16'(n / 5));
        check("busy_flag", 16'(busy),    16'd1);
      end
    end
    start = 1'b0;
  endtask

  logic [3:0]  e_err, e_ff;
  logic        e_pass;
  logic [15:0] e_sig;
  int          n;
`ifdef VECTOR_SEQUENCER_MISR_EN
  logic [15:0] sig_run1;
`endif

  initial begin
    start    = 1'b0;
    start16  = 1'b0;
    y16      = 4'hF;
    zero_vec = -1;
    for (int k = 0; k < 16; k++) fault_mask[k] = 4'd0;

    // Reset state, sampled while reset is held.
    reset = 1'b0;
    #12;
    check("rst_a",    16'(a_out),      16'd0);
    check("rst_b",    16'(b_out),      16'd0);
    check("rst_c",    16'(c_out),      16'd0);
    check("rst_idx",  16'(vec_idx),    16'd0);
    check("rst_err",  16'(err_count),  16'd0);
    check("rst_busy", 16'(busy),       16'd0);
    check("rst_done", 16'(done),       16'd0);
    check("rst_pass", 16'(pass),       16'd0);
    check("rst_ff",   16'(first_fail), 16'hF);
`ifdef VECTOR_SEQUENCER_MISR_EN
    check("rst_sig",  signature,       16'hFFFF);
`endif
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", 16'(busy), 16'd0);

    // Golden run: 50 clocks, clean result, last stimulus held in DONE.
    model_run(e_err, e_ff, e_pass, e_sig);
    run_dut(1'b0, n);
    check("gold_cycles", 16'(n),          16'd50);
    check("gold_pass",   16'(pass),       16'(e_pass));
    check("gold_err",    16'(err_count),  16'(e_err));
    check("gold_ff",     16'(first_fail), 16'(e_ff));
`ifdef VECTOR_SEQUENCER_MISR_EN
    check("gold_sig",    signature,       e_sig);
    sig_run1 = signature;
`endif
    repeat (3) @(negedge clk);
    check("hold_done", 16'(done),  16'd1);
    check("hold_busy", 16'(busy),  16'd0);
    check("hold_a",    16'(a_out), 16'(REF_A[NV-1]));
    check("hold_b",    16'(b_out), 16'(REF_B[NV-1]));
    check("hold_c",    16'(c_out), 16'(REF_C[NV-1]));

    // Single fault: response forced to zero during vector 5 only.
    zero_vec = 5;
    model_run(e_err, e_ff, e_pass, e_sig);
    run_dut(1'b0, n);
    check("f5_cycles", 16'(n),          16'd50);
    check("f5_pass",   16'(pass),       16'(e_pass));
    check("f5_err",    16'(err_count),  16'(e_err));
    check("f5_ff",     16'(first_fail), 16'(e_ff));
    zero_vec = -1;

    // Restart from DONE (cleared counters checked inside run_dut) with
    // start pulses sprinkled over the busy window.
    model_run(e_err, e_ff, e_pass, e_sig);
    run_dut(1'b1, n);
    check("spur_cycles", 16'(n),          16'd50);
    check("spur_pass",   16'(pass),       16'(e_pass));
    check("spur_ff",     16'(first_fail), 16'(e_ff));
`ifdef VECTOR_SEQUENCER_MISR_EN
    check("sig_repeat",  signature,       sig_run1);
`endif

`ifdef VECTOR_SEQUENCER_MISR_EN
    // A single-bit flip on vector 2 must disturb the signature.
    fault_mask[2] = 4'h1;
    model_run(e_err, e_ff, e_pass, e_sig);
    run_dut(1'b0, n);
    check("flip_sig",    signature,          e_sig);
    check("flip_differs", 16'(signature != sig_run1), 16'd1);
    fault_mask[2] = 4'h0;
`endif

    // Randomized fault patterns against the model.
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < NV; k++) begin
        fault_mask[k] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      end
      model_run(e_err, e_ff, e_pass, e_sig);
      run_dut(1'b0, n);
      check("rnd_cycles", 16'(n),          16'd50);
      check("rnd_err",    16'(err_count),  16'(e_err));
      check("rnd_ff",     16'(first_fail), 16'(e_ff));
      check("rnd_pass",   16'(pass),       16'(e_pass));
`ifdef VECTOR_SEQUENCER_MISR_EN
      check("rnd_sig",    signature,       e_sig);
`endif
    end
    for (int k = 0; k < 16; k++) fault_mask[k] = 4'd0;

    // Saturation on the 16-vector build: every response wrong.
    @(negedge clk); start16 = 1'b1;
    @(negedge clk); start16 = 1'b0;
    n = 0;
    while (!done16 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("sat_cycles", 16'(n),     16'd80);
    check("sat_err",    16'(err16), 16'd15);
    check("sat_ff",     16'(ff16),  16'd0);
    check("sat_pass",   16'(pass16), 16'd0);

    // Reset during the SETTLE of vector 4: outputs clear immediately.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (21) @(negedge clk);
    check("mid_idx_pre", 16'(vec_idx), 16'd4);
    #2 reset = 1'b0;
    #1;
    check("mid_a",    16'(a_out),      16'd0);
    check("mid_b",    16'(b_out),      16'd0);
    check("mid_c",    16'(c_out),      16'd0);
    check("mid_idx",  16'(vec_idx),    16'd0);
    check("mid_err",  16'(err_count),  16'd0);
    check("mid_busy", 16'(busy),       16'd0);
    check("mid_done", 16'(done),       16'd0);
    check("mid_pass", 16'(pass),       16'd0);
    check("mid_ff",   16'(first_fail), 16'hF);
    @(negedge clk); reset = 1'b1;
    repeat (10) @(negedge clk);
    check("post_busy", 16'(busy),  16'd0);
    check("post_done", 16'(done),  16'd0);
    check("post_a",    16'(a_out), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
